// File: rtl/boot_seq_pkg.sv
// Shared types for the UART boot sequencer: state encoding, output bundle and
// the Moore output decode used by the top-level FSM.
package boot_seq_pkg;

    localparam int unsigned BOOT_STATE_W = 3;

    localparam logic [7:0] BOOT_ANNOUNCE_BYTE = 8'h99;
    localparam logic [7:0] BOOT_READY_BYTE    = 8'hAA;

    typedef enum logic [BOOT_STATE_W-1:0] {
        ST_WAIT_START = 3'd0,
        ST_SEND_99    = 3'd1,
        ST_RECV_SIZE  = 3'd2,
        ST_RECV_PROG  = 3'd3,
        ST_SEND_AA    = 3'd4,
        ST_RUN        = 3'd5,
        ST_ERROR      = 3'd7
    } boot_state_t;

    typedef struct packed {
        logic transmit_0x99;
        logic receive_program_data_size;
        logic receive_program_data;
        logic transmit_0xAA;
        logic receive_stdin_data;
        logic transmit_stdout_data;
        logic cpu_reset_n;
        logic boot_done;
        logic boot_error;
    } boot_outputs_t;

    // States in which the sequencer waits on the host and the watchdog runs.
    function automatic logic is_wait_phase(boot_state_t s);
        return (s == ST_SEND_99) || (s == ST_RECV_SIZE) ||
               (s == ST_RECV_PROG) || (s == ST_SEND_AA);
    endfunction

    function automatic boot_outputs_t decode_outputs(boot_state_t s);
        boot_outputs_t o;
        o = '0;
        case (s)
            ST_SEND_99:   o.transmit_0x99             = 1'b1;
            ST_RECV_SIZE: o.receive_program_data_size = 1'b1;
            ST_RECV_PROG: o.receive_program_data      = 1'b1;
            ST_SEND_AA:   o.transmit_0xAA             = 1'b1;
            ST_RUN: begin
                o.receive_stdin_data   = 1'b1;
                o.transmit_stdout_data = 1'b1;
                o.cpu_reset_n          = 1'b1;
                o.boot_done            = 1'b1;
            end
            ST_ERROR:     o.boot_error                = 1'b1;
            default:      o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/uart_boot_sequencer_if.sv
// Mode-request / done-flag handshake between the boot sequencer (master)
// and the UART controller (slave).
interface uart_boot_sequencer_if;

    logic transmit_0x99;
    logic receive_program_data_size;
    logic receive_program_data;
    logic transmit_0xAA;
    logic receive_stdin_data;
    logic transmit_stdout_data;

    logic transmit_0x99_finished;
    logic receive_program_data_size_finished;
    logic receive_program_data_finished;
    logic transmit_0xAA_finished;
    logic rx_activity;

    modport master (
        output transmit_0x99,
        output receive_program_data_size,
        output receive_program_data,
        output transmit_0xAA,
        output receive_stdin_data,
        output transmit_stdout_data,
        input  transmit_0x99_finished,
        input  receive_program_data_size_finished,
        input  receive_program_data_finished,
        input  transmit_0xAA_finished,
        input  rx_activity
    );

    modport slave (
        input  transmit_0x99,
        input  receive_program_data_size,
        input  receive_program_data,
        input  transmit_0xAA,
        input  receive_stdin_data,
        input  transmit_stdout_data,
        output transmit_0x99_finished,
        output receive_program_data_size_finished,
        output receive_program_data_finished,
        output transmit_0xAA_finished,
        output rx_activity
    );

endinterface

// File: rtl/boot_watchdog.sv
// Saturating inactivity counter; expired flags the last cycle before the
// TIMEOUT_CYCLES limit. TIMEOUT_CYCLES of 0 disarms it permanently.
module boot_watchdog #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
    parameter int unsigned TIMEOUT_WIDTH  = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam bit                       ARMED   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

    logic [TIMEOUT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear || !enable) begin
            count_q <= '0;
        end else if (count_q != CNT_MAX) begin
            count_q <= count_q + TIMEOUT_WIDTH'(1);
        end
    end

    assign expired = ARMED && enable && (count_q == LIMIT);

endmodule

// File: rtl/uart_boot_sequencer.sv
// Boot sequencer: steps the UART controller through announce, size, image,
// ready and console modes, releasing the CPU core only once the image is in.
import boot_seq_pkg::*;

module uart_boot_sequencer #(
    parameter int unsigned STARTUP_DELAY  = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
    parameter int unsigned TIMEOUT_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    uart_boot_sequencer_if.master    uart,
    output logic                     cpu_reset_n,
    output logic                     boot_done,
    output logic                     boot_error,
    output logic [BOOT_STATE_W-1:0]  boot_state
);

    localparam int unsigned       DELAY_W    = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
    localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(STARTUP_DELAY - 1);

    boot_state_t        state_q;
    boot_state_t        state_d;
    boot_outputs_t      outs_q;
    boot_outputs_t      outs_d;
    logic [DELAY_W-1:0] delay_q;
    logic               wd_enable;
    logic               wd_clear;
    logic               wd_expired;

    boot_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (wd_enable),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    // Outputs register the decode of the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_WAIT_START;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            delay_q <= '0;
        end else if ((state_q == ST_WAIT_START) && (delay_q != DELAY_LAST)) begin
            delay_q <= delay_q + DELAY_W'(1);
        end
    end

    // A done flag beats a coinciding watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_START: begin
                if (delay_q == DELAY_LAST) state_d = ST_SEND_99;
            end
            ST_SEND_99: begin
                if (uart.transmit_0x99_finished)                  state_d = ST_RECV_SIZE;
                else if (wd_expired)                              state_d = ST_ERROR;
            end
            ST_RECV_SIZE: begin
                if (uart.receive_program_data_size_finished)      state_d = ST_RECV_PROG;
                else if (wd_expired)                              state_d = ST_ERROR;
            end
            ST_RECV_PROG: begin
                if (uart.receive_program_data_finished)           state_d = ST_SEND_AA;
                else if (wd_expired)                              state_d = ST_ERROR;
            end
            ST_SEND_AA: begin
                if (uart.transmit_0xAA_finished)                  state_d = ST_RUN;
                else if (wd_expired)                              state_d = ST_ERROR;
            end
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        wd_enable = is_wait_phase(state_q);
        wd_clear  = (state_d != state_q) || uart.rx_activity;
        outs_d    = decode_outputs(state_d);
    end

    assign uart.transmit_0x99             = outs_q.transmit_0x99;
    assign uart.receive_program_data_size = outs_q.receive_program_data_size;
    assign uart.receive_program_data      = outs_q.receive_program_data;
    assign uart.transmit_0xAA             = outs_q.transmit_0xAA;
    assign uart.receive_stdin_data        = outs_q.receive_stdin_data;
    assign uart.transmit_stdout_data      = outs_q.transmit_stdout_data;
    assign cpu_reset_n                    = outs_q.cpu_reset_n;
    assign boot_done                      = outs_q.boot_done;
    assign boot_error                     = outs_q.boot_error;
    assign boot_state                     = state_q;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Directed bench for uart_boot_sequencer: nominal boot, sticky flags, timeout,
// watchdog restart, finished/expiry coincidence and mid-boot reset.
module tb_uart_boot_sequencer;

    logic       clk;
    logic       reset_n;
    logic       cpu_reset_n;
    logic       boot_done;
    logic       boot_error;
    logic [2:0] boot_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int overlap_cnt  = 0;

    uart_boot_sequencer_if bus ();

    uart_boot_sequencer #(
        .STARTUP_DELAY  (16),
        .TIMEOUT_CYCLES (32'd100),
        .TIMEOUT_WIDTH  (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart        (bus),
        .cpu_reset_n (cpu_reset_n),
        .boot_done   (boot_done),
        .boot_error  (boot_error),
        .boot_state  (boot_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] reqs();
        return {bus.transmit_0x99, bus.receive_program_data_size,
                bus.receive_program_data, bus.transmit_0xAA};
    endfunction

    always @(negedge clk) begin
        if (reset_n === 1'b1 && $countones(reqs()) > 1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.transmit_0x99_finished             = 1'b0;
        bus.receive_program_data_size_finished = 1'b0;
        bus.receive_program_data_finished      = 1'b0;
        bus.transmit_0xAA_finished             = 1'b0;
        bus.rx_activity                        = 1'b0;
        tick();
        tick();
    endtask

    task automatic set_flag(input int s);
        case (s)
            1: bus.transmit_0x99_finished             = 1'b1;
            2: bus.receive_program_data_size_finished = 1'b1;
            3: bus.receive_program_data_finished      = 1'b1;
            4: bus.transmit_0xAA_finished             = 1'b1;
            default: ;
        endcase
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_state"}, 32'(boot_state), 32'd0);
        check({tag, "_reqs"}, 32'(reqs()), 32'd0);
        check({tag, "_console"}, 32'({bus.receive_stdin_data, bus.transmit_stdout_data}), 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_reset_n), 32'd0);
        check({tag, "_done_err"}, 32'({boot_done, boot_error}), 32'd0);
    endtask

    // Reset, release, and walk through SEND_99 and RECV_SIZE into RECV_PROG.
    task automatic goto_recv_prog(input string tag);
        apply_reset();
        reset_n = 1'b1;
        repeat (16) tick();
        check({tag, "_st99"}, 32'(boot_state), 32'd1);
        set_flag(1);
        tick();
        check({tag, "_stsize"}, 32'(boot_state), 32'd2);
        set_flag(2);
        tick();
        check({tag, "_stprog"}, 32'(boot_state), 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL tb_time_limit: simulation did not complete, got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        apply_reset();
        check_all_low("rst");

        // Nominal boot: flags 5 cycles after each request rises
        reset_n = 1'b1;
        repeat (15) tick();
        check("nom_delay_state", 32'(boot_state), 32'd0);
        check("nom_delay_reqs", 32'(reqs()), 32'd0);
        tick();
        check("nom_99_rise_state", 32'(boot_state), 32'd1);
        for (int s = 1; s <= 4; s++) begin
            check($sformatf("nom_req_s%0d", s), 32'(reqs()), 32'(4'b1000 >> (s - 1)));
            check($sformatf("nom_cpu_held_s%0d", s), 32'(cpu_reset_n), 32'd0);
            repeat (4) tick();
            check($sformatf("nom_hold_s%0d", s), 32'(boot_state), 32'(s));
            set_flag(s);
            tick();
            check($sformatf("nom_adv_s%0d", s), 32'(boot_state), 32'(s + 1));
        end
        check("nom_run_reqs", 32'(reqs()), 32'd0);
        check("nom_run_console", 32'({bus.receive_stdin_data, bus.transmit_stdout_data}), 32'd3);
        check("nom_run_cpu", 32'(cpu_reset_n), 32'd1);
        check("nom_run_done_err", 32'({boot_done, boot_error}), 32'b10);
        repeat (3) tick();
        check("nom_run_stays", 32'(boot_state), 32'd5);

        // Sticky early flags: one cycle per wait state, RUN at cycle 20
        apply_reset();
        for (int s = 1; s <= 4; s++) set_flag(s);
        reset_n = 1'b1;
        repeat (16) tick();
        check("sticky_s1", 32'(boot_state), 32'd1);
        for (int s = 2; s <= 5; s++) begin
            tick();
            check($sformatf("sticky_s%0d", s), 32'(boot_state), 32'(s));
        end
        check("sticky_cpu", 32'(cpu_reset_n), 32'd1);

        // Timeout in RECV_PROG: ERROR 100 cycles after entry
        goto_recv_prog("to");
        repeat (99) tick();
        check("to_before_expiry", 32'(boot_state), 32'd3);
        tick();
        check("to_state", 32'(boot_state), 32'd7);
        check("to_boot_error", 32'(boot_error), 32'd1);
        check("to_cpu", 32'(cpu_reset_n), 32'd0);
        check("to_reqs", 32'(reqs()), 32'd0);
        check("to_console", 32'({bus.receive_stdin_data, bus.transmit_stdout_data}), 32'd0);
        set_flag(3);
        repeat (3) tick();
        check("to_terminal", 32'(boot_state), 32'd7);

        // Watchdog restart via rx_activity every 90 cycles
        goto_recv_prog("wr");
        for (int i = 0; i < 1000; i++) begin
            bus.rx_activity = ((i % 90) == 89);
            tick();
        end
        bus.rx_activity = 1'b0;
        check("wr_no_error", 32'(boot_state), 32'd3);
        set_flag(3);
        tick();
        check("wr_adv_aa", 32'(boot_state), 32'd4);
        set_flag(4);
        tick();
        check("wr_run", 32'(boot_state), 32'd5);

        // Finished flag on the expiry cycle wins
        goto_recv_prog("co");
        repeat (99) tick();
        check("co_pre", 32'(boot_state), 32'd3);
        set_flag(3);
        tick();
        check("co_adv", 32'(boot_state), 32'd4);
        check("co_no_error", 32'(boot_error), 32'd0);

        // Mid-boot reset in RECV_SIZE
        apply_reset();
        reset_n = 1'b1;
        repeat (16) tick();
        set_flag(1);
        tick();
        check("mr_in_size", 32'(boot_state), 32'd2);
        reset_n = 1'b0;
        bus.transmit_0x99_finished = 1'b0;
        tick();
        check_all_low("mr");
        reset_n = 1'b1;
        repeat (15) tick();
        check("mr_delay", 32'(boot_state), 32'd0);
        tick();
        check("mr_restart_99", 32'(boot_state), 32'd1);
        check("mr_restart_req", 32'(reqs()), 32'b1000);

        check("no_req_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_boot_sequencer.md
Name: uart_boot_sequencer

Overview:
- Top-level sequencer for the UART boot and console datapath.
- Drives the mode-request levels of the UART controller in a fixed order:
  - announce 0x99;
  - receive 4-byte program size;
  - receive program image;
  - announce 0xAA;
  - console (stdin/stdout) mode.
- Holds the CPU core in reset until the image is loaded.
- Watchdog timeout during the host-interaction phases; an unrecoverable error state.
- Sits between top-level reset logic, the UART controller and the CPU core.

Parameters:
- STARTUP_DELAY, 16, cycles to wait after reset before requesting the 0x99 announce (line settle); minimum 1.
- TIMEOUT_CYCLES, 32'd100_000_000, watchdog limit in clk cycles for each wait phase; 0 disables the watchdog.
- TIMEOUT_WIDTH, 32, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- rx_activity  in  1  one-cycle strobe per received UART byte (rdata_ready); restarts the watchdog
- transmit_0x99_finished  in  1  sticky done flag from the UART controller
- receive_program_data_size_finished  in  1  sticky done flag
- receive_program_data_finished  in  1  sticky done flag
- transmit_0xAA_finished  in  1  sticky done flag
- transmit_0x99  out  1  request level
- receive_program_data_size  out  1  request level
- receive_program_data  out  1  request level
- transmit_0xAA  out  1  request level
- receive_stdin_data  out  1  console-mode level
- transmit_stdout_data  out  1  console-mode level
- cpu_reset_n  out  1  active-low reset to the CPU core; registered
- boot_done  out  1  high in RUN
- boot_error  out  1  high in ERROR
- boot_state  out  3  encoded current state, for debug/LED

Behaviour:
- Reset is synchronous and active-low; clock is clk.
- While reset_n=0:
  - state goes to WAIT_START;
  - delay counter and watchdog counter go to 0;
  - every output is 0; cpu_reset_n=0.
- All outputs are a Moore decode of the registered state; there is no combinational path from any input to any output.
- A request output falls at the same edge at which its finished flag is sampled 1. This gives exactly one cycle of overlap with the finished flag.
- States, their asserted outputs and transitions:
  - WAIT_START: no requests.
    - The delay counter increments each cycle.
    - When the counter reaches STARTUP_DELAY-1, go to SEND_99.
  - SEND_99: transmit_0x99=1.
    - transmit_0x99_finished=1 -> RECV_SIZE.
  - RECV_SIZE: receive_program_data_size=1.
    - receive_program_data_size_finished=1 -> RECV_PROG.
  - RECV_PROG: receive_program_data=1.
    - receive_program_data_finished=1 -> SEND_AA.
  - SEND_AA: transmit_0xAA=1.
    - transmit_0xAA_finished=1 -> RUN.
  - RUN: receive_stdin_data=1, transmit_stdout_data=1, cpu_reset_n=1, boot_done=1.
    - RUN is terminal until reset.
  - ERROR: boot_error=1, all requests 0, cpu_reset_n=0.
    - ERROR is terminal until reset.
- At most one of the four boot request outputs is 1 in any cycle.
- Watchdog (active only in SEND_99, RECV_SIZE, RECV_PROG, SEND_AA):
  - clears to 0 on every state change and on every cycle with rx_activity=1;
  - otherwise increments by 1 per cycle, saturating;
  - when it equals TIMEOUT_CYCLES-1 and the state's finished flag is 0, the next state is ERROR;
  - if the finished flag and timeout coincide, the finished flag wins (normal advance).
- TIMEOUT_CYCLES=0: the watchdog never fires.
- Finished flags arriving early (already 1 on state entry, because they are sticky) cause an advance after exactly one cycle in that state.
- Finished flags belonging to a non-current state are ignored.
- boot_state encoding: WAIT_START=0, SEND_99=1, RECV_SIZE=2, RECV_PROG=3, SEND_AA=4, RUN=5, ERROR=7.
- Reset mid-operation: immediate return to WAIT_START, and cpu_reset_n=0 at the next edge. The UART controller shares the same reset, so its sticky flags clear together with the sequencer.

Decomposition:
- Package boot_seq_pkg holds:
  - boot_state_t enum with the encodings above;
  - constants BOOT_ANNOUNCE_BYTE=8'h99 and BOOT_READY_BYTE=8'hAA, informational for benches.
- One sub-module, boot_watchdog, contains the counter plus the expired flag.
  - Inputs: clk, reset_n, enable, clear.
  - Output: expired.
  - Parameters: TIMEOUT_CYCLES, TIMEOUT_WIDTH.

Test Plan:
- Nominal boot, STARTUP_DELAY=16:
  - stimulus: raise each finished flag 5 cycles after its request rises;
  - response: transmit_0x99 rises at cycle 16 after reset release; states follow 1,2,3,4,5; cpu_reset_n=1 and both console levels =1 in RUN; no two requests ever high together.
- Sticky early flags:
  - stimulus: all four finished flags held at 1 from reset release;
  - response: exactly one cycle in each of SEND_99..SEND_AA; RUN reached at cycle STARTUP_DELAY+4.
- Timeout, TIMEOUT_CYCLES=100, in RECV_PROG:
  - stimulus: no rx_activity and no finished flag;
  - response: ERROR 100 cycles after entry; boot_error=1, cpu_reset_n=0, all requests 0, boot_state=7.
- Watchdog restart, TIMEOUT_CYCLES=100, in RECV_PROG:
  - stimulus: rx_activity every 90 cycles for 1000 cycles, then receive_program_data_finished=1;
  - response: no ERROR; advance to SEND_AA.
- Finished/timeout coincidence and mid-boot reset:
  - stimulus 1: finished flag on the expiry cycle; response: advance, not ERROR;
  - stimulus 2: reset_n=0 for 1 cycle while in RECV_SIZE; response: WAIT_START, all outputs 0, boot restarts with the 16-cycle delay.
